// File: rtl/butterfly_wb.sv
// NTT butterfly write-back: buffers result pairs in a small FIFO and serialises
// each pair into two single-coefficient RAM writes (a then b), honouring mem_gnt_i.
// Ports: clk_i, rst_n_i, valid_i/ready_o (pair handshake), a_out_i, b_out_i,
// addr_a_i, addr_b_i, mem_we_o/mem_addr_o/mem_wdata_o/mem_gnt_i (RAM write port),
// empty_o (all writes retired), err_o (sticky range error).
// Optional macro BFLY_WB_RANGE_CHK_EN enables the sticky err_o range check
// against Q_MOD; without it err_o is tied low.
module butterfly_wb #(
    parameter int DATA_W = 23,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4,
    parameter int Q_MOD  = 8380417
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] a_out_i,
    input  logic [DATA_W-1:0] b_out_i,
    input  logic [ADDR_W-1:0] addr_a_i,
    input  logic [ADDR_W-1:0] addr_b_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    output logic              empty_o,
    output logic              err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("butterfly_wb: DEPTH must be a power of two >= 2");
    end
    if ((Q_MOD <= 0) || (Q_MOD >= (1 << DATA_W))) begin : g_bad_q
        $error("butterfly_wb: Q_MOD must fit in DATA_W bits");
    end

    typedef enum logic [1:0] {IDLE, WR_A, WR_B} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [ADDR_W-1:0] addr_a;
        logic [ADDR_W-1:0] addr_b;
    } entry_t;

    entry_t             fifo_q [DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_nxt;
    state_t             state_q;
    logic               push;
    logic               pop;

    assign ready_o   = (count_q != CNT_W'(DEPTH));
    assign push      = valid_i & ready_o;
    assign pop       = (state_q == WR_B) & mem_gnt_i;
    assign count_nxt = count_q + CNT_W'(push) - CNT_W'(pop);
    assign head      = fifo_q[rd_ptr_q];
    assign empty_o   = (count_q == '0) & (state_q == IDLE);

    // Payload storage carries no reset: it is only observed while the FSM
    // is in WR_A/WR_B, which requires a push after reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{a: a_out_i, b: b_out_i,
                                  addr_a: addr_a_i, addr_b: addr_b_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_nxt;
        end
    end

    // Leaving WR_B looks at the post-pop occupancy (including a same-cycle
    // push) so back-to-back pairs stream at one pair per two cycles.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (count_q != '0) state_q <= WR_A;
                WR_A: if (mem_gnt_i) state_q <= WR_B;
                WR_B: if (mem_gnt_i) state_q <= (count_nxt != '0) ? WR_A : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        unique case (state_q)
            WR_A: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = head.addr_a;
                mem_wdata_o = head.a;
            end
            WR_B: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = head.addr_b;
                mem_wdata_o = head.b;
            end
            default: ;
        endcase
    end

`ifdef BFLY_WB_RANGE_CHK_EN
    localparam logic [DATA_W-1:0] Q_VAL = DATA_W'(Q_MOD);
    logic err_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
        end else if (push && ((a_out_i >= Q_VAL) || (b_out_i >= Q_VAL))) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_butterfly_wb.sv
// Self-checking bench for butterfly_wb: vector table for single-pair latency,
// scoreboard queue of expected RAM writes, plus stall/fill/stream/reset/range sequences.
module tb_butterfly_wb;

    localparam int DW = 23;
    localparam int AW = 8;
    localparam int QM = 8380417;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid;
    logic          ready;
    logic [DW-1:0] a_out;
    logic [DW-1:0] b_out;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          gnt;
    logic          empty;
    logic          err;

    butterfly_wb dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .valid_i    (valid),
        .ready_o    (ready),
        .a_out_i    (a_out),
        .b_out_i    (b_out),
        .addr_a_i   (addr_a),
        .addr_b_i   (addr_b),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_gnt_i  (gnt),
        .empty_o    (empty),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            is_b;
    } wr_t;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [AW-1:0] aa;
        logic [AW-1:0] ab;
        logic [AW-1:0] exp_addr_a;
        logic [DW-1:0] exp_data_a;
        logic [AW-1:0] exp_addr_b;
        logic [DW-1:0] exp_data_b;
    } vec_t;

    wr_t  exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   occ = 0;
    int   max_occ = 0;
    int   accepted = 0;
    int   writes_seen = 0;
    bit   err_model = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: sampled at negedge, i.e. what will happen at the next posedge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we && gnt) begin
                writes_seen++;
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(e.addr));
                    check("wr_data", 32'(mem_wdata), 32'(e.data));
                    if (e.is_b) occ--;
                end
            end
            if (valid && ready) begin
                exp_q.push_back('{addr: addr_a, data: a_out, is_b: 1'b0});
                exp_q.push_back('{addr: addr_b, data: b_out, is_b: 1'b1});
                accepted++;
                occ++;
                if (occ > max_occ) max_occ = occ;
`ifdef BFLY_WB_RANGE_CHK_EN
                if (a_out >= DW'(QM) || b_out >= DW'(QM)) err_model = 1'b1;
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one pair and hold it until accepted; returns 1 ns after the push edge.
    task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [AW-1:0] aa, input logic [AW-1:0] ab);
        bit done;
        done   = 1'b0;
        valid  = 1'b1;
        a_out  = a;
        b_out  = b;
        addr_a = aa;
        addr_b = ab;
        for (int i = 0; i < 100 && !done; i++) begin
            done = ready;
            tick();
        end
        if (!done) check("push_timeout", 32'd1, 32'd0);
        valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (empty && exp_q.size() == 0) ok = 1'b1;
            else tick();
        end
        check("drain_idle", 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        exp_q.delete();
        occ = 0;
        err_model = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{23'd5, 23'd8380416, 8'h10, 8'h90,
                    8'h10, 23'd5, 8'h90, 23'd8380416};
        vecs[1] = '{23'd0, 23'd0, 8'h00, 8'hFF,
                    8'h00, 23'd0, 8'hFF, 23'd0};
        vecs[2] = '{23'd8380416, 23'd1, 8'h33, 8'h33,
                    8'h33, 23'd8380416, 8'h33, 23'd1};
        vecs[3] = '{23'h2AAAAA, 23'h555555, 8'h7F, 8'h80,
                    8'h7F, 23'h2AAAAA, 8'h80, 23'h555555};

        rst_n  = 1'b0;
        valid  = 1'b0;
        gnt    = 1'b0;
        a_out  = '0;
        b_out  = '0;
        addr_a = '0;
        addr_b = '0;
        #12;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        do_reset();

        // Single-pair latency, gnt held high.
        gnt = 1'b1;
        for (int v = 0; v < 4; v++) begin
            push_pair(vecs[v].a, vecs[v].b, vecs[v].aa, vecs[v].ab);
            check("lat_idle_we", 32'(mem_we), 32'd0);
            tick();
            check("lat_a_we", 32'(mem_we), 32'd1);
            check("lat_a_addr", 32'(mem_addr), 32'(vecs[v].exp_addr_a));
            check("lat_a_data", 32'(mem_wdata), 32'(vecs[v].exp_data_a));
            tick();
            check("lat_b_we", 32'(mem_we), 32'd1);
            check("lat_b_addr", 32'(mem_addr), 32'(vecs[v].exp_addr_b));
            check("lat_b_data", 32'(mem_wdata), 32'(vecs[v].exp_data_b));
            tick();
            check("lat_done_we", 32'(mem_we), 32'd0);
            check("lat_done_empty", 32'(empty), 32'd1);
        end

        // Stall in WR_A.
        gnt = 1'b0;
        push_pair(23'd5, 23'd8380416, 8'h10, 8'h90);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_we", 32'(mem_we), 32'd1);
            check("stall_addr", 32'(mem_addr), 32'h10);
            check("stall_data", 32'(mem_wdata), 32'd5);
        end
        gnt = 1'b1;
        tick();
        check("stall_b_addr", 32'(mem_addr), 32'h90);
        check("stall_b_data", 32'(mem_wdata), 32'd8380416);
        tick();
        check("stall_end_we", 32'(mem_we), 32'd0);
        wait_idle();

        // Fill and backpressure.
        gnt = 1'b0;
        for (int i = 0; i < 4; i++) push_pair(DW'(i), DW'(100 + i), AW'(i), AW'(128 + i));
        check("full_ready", 32'(ready), 32'd0);
        valid  = 1'b1;
        a_out  = 23'd99;
        b_out  = 23'd199;
        addr_a = 8'd77;
        addr_b = 8'd78;
        tick();
        tick();
        check("full_hold_ready", 32'(ready), 32'd0);
        check("full_accepted", 32'(accepted), 32'd9);
        valid = 1'b0;
        gnt   = 1'b1;
        tick();
        check("full_ready_wrb", 32'(ready), 32'd0);
        tick();
        check("full_ready_pop", 32'(ready), 32'd1);
        wait_idle();

        // Streaming across pointer wrap.
        max_occ  = 0;
        accepted = 0;
        gnt = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 4) gnt = 1'b1;
            push_pair(DW'($urandom_range(0, QM - 1)), DW'($urandom_range(0, QM - 1)),
                      AW'($urandom_range(0, 255)), AW'($urandom_range(0, 255)));
        end
        wait_idle();
        check("stream_accepted", 32'(accepted), 32'd16);
        check("stream_max_occ", 32'(max_occ), 32'd4);

        // Reset while in WR_B with 3 entries.
        gnt = 1'b0;
        for (int i = 0; i < 3; i++) push_pair(DW'(10 + i), DW'(20 + i), AW'(40 + i), AW'(50 + i));
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        check("mid_wrb_addr", 32'(mem_addr), 32'd50);
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", 32'(mem_we), 32'd0);
        exp_q.delete();
        occ = 0;
        err_model = 1'b0;
        writes_seen = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("post_rst_empty", 32'(empty), 32'd1);
        check("post_rst_ready", 32'(ready), 32'd1);
        gnt = 1'b1;
        repeat (10) tick();
        check("post_rst_writes", 32'(writes_seen), 32'd0);

        // Range check.
        push_pair(DW'(QM), 23'd0, 8'h01, 8'h02);
        check("rng_err_set", 32'(err), 32'(err_model));
        wait_idle();
        push_pair(23'd7, 23'd8, 8'h03, 8'h04);
        check("rng_err_sticky", 32'(err), 32'(err_model));
        wait_idle();
`ifndef BFLY_WB_RANGE_CHK_EN
        check("rng_err_off", 32'(err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
